// File: rtl/alu_seq_ctrl.sv
// Multi-cycle Moore controller sequencing the register-file/ALU datapath, one instruction per s.
// Build option: define ALU_SEQ_ILLEGAL_TRAP_EN to trap on illegal encodings instead of a NOP.
module alu_seq_ctrl #(
   parameter int unsigned NSEL_W = 3,
   parameter int unsigned VSEL_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   output logic              w,
   output logic [NSEL_W-1:0] nsel,
   output logic [VSEL_W-1:0] vsel,
   output logic              write,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        alu_op,
   output logic              err
);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   typedef enum logic [2:0] {
      StWait   = 3'd0,
      StDecode = 3'd1,
      StMovImm = 3'd2,
      StGetA   = 3'd3,
      StGetB   = 3'd4,
      StExec   = 3'd5,
      StWrite  = 3'd6,
      StTrap   = 3'd7
   } state_e;
`else
   typedef enum logic [2:0] {
      StWait   = 3'd0,
      StDecode = 3'd1,
      StMovImm = 3'd2,
      StGetA   = 3'd3,
      StGetB   = 3'd4,
      StExec   = 3'd5,
      StWrite  = 3'd6
   } state_e;
`endif

   state_e     state_q, state_d;
   logic [2:0] opcode_q, opcode_d;
   logic [1:0] op_q, op_d;

   logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;

   assign is_mov_imm = (opcode_q == 3'b110) && (op_q == 2'b10);
   assign is_mov_reg = (opcode_q == 3'b110) && (op_q == 2'b00);
   assign is_add     = (opcode_q == 3'b101) && (op_q == 2'b00);
   assign is_cmp     = (opcode_q == 3'b101) && (op_q == 2'b01);
   assign is_and     = (opcode_q == 3'b101) && (op_q == 2'b10);
   assign is_mvn     = (opcode_q == 3'b101) && (op_q == 2'b11);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StWait;
         opcode_q <= 3'b000;
         op_q     <= 2'b00;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         op_q     <= op_d;
      end
   end

   // Fields are captured only on the start edge so later input changes cannot disturb execution.
   always_comb begin
      opcode_d = opcode_q;
      op_d     = op_q;
      if ((state_q == StWait) && s) begin
         opcode_d = opcode;
         op_d     = op;
      end
   end

   always_comb begin
      state_d = StWait;
      case (state_q)
         StWait:   state_d = s ? StDecode : StWait;
         StDecode: begin
            if (is_mov_imm) begin
               state_d = StMovImm;
            end else if (is_mov_reg || is_mvn) begin
               state_d = StGetB;
            end else if (is_add || is_cmp || is_and) begin
               state_d = StGetA;
            end else begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
               state_d = StTrap;
`else
               state_d = StWait;
`endif
            end
         end
         StMovImm: state_d = StWait;
         StGetA:   state_d = StGetB;
         StGetB:   state_d = StExec;
         StExec:   state_d = is_cmp ? StWait : StWrite;
         StWrite:  state_d = StWait;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
         StTrap:   state_d = StTrap;
`endif
         default:  state_d = StWait;
      endcase
   end

   always_comb begin
      w      = 1'b0;
      nsel   = '0;
      vsel   = '0;
      write  = 1'b0;
      loada  = 1'b0;
      loadb  = 1'b0;
      loadc  = 1'b0;
      loads  = 1'b0;
      asel   = 1'b0;
      bsel   = 1'b0;
      alu_op = 2'b00;
      err    = 1'b0;
      case (state_q)
         StWait: w = 1'b1;
         StMovImm: begin
            nsel  = NSEL_W'(3'b001);
            vsel  = VSEL_W'(2'b10);
            write = 1'b1;
         end
         StGetA: begin
            nsel  = NSEL_W'(3'b001);
            loada = 1'b1;
         end
         StGetB: begin
            nsel  = NSEL_W'(3'b100);
            loadb = 1'b1;
         end
         StExec: begin
            asel  = is_mov_reg || is_mvn;
            loads = is_cmp;
            loadc = !is_cmp;
            if (is_cmp) begin
               alu_op = 2'b01;
            end else if (is_and) begin
               alu_op = 2'b10;
            end else if (is_mvn) begin
               alu_op = 2'b11;
            end else begin
               alu_op = 2'b00;
            end
         end
         StWrite: begin
            nsel  = NSEL_W'(3'b010);
            vsel  = VSEL_W'(2'b01);
            write = 1'b1;
         end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
         StTrap: err = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: per-instruction output-sequence model plus directed checks.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       s = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic [1:0] op = 2'b00;
   logic       w, write, loada, loadb, loadc, loads, asel, bsel, err;
   logic [2:0] nsel;
   logic [1:0] vsel, alu_op;

   int n_chk = 0;
   int n_fail = 0;

   // {w, err, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op}
   localparam logic [15:0] WAIT_V = 16'b1_0_000_00_0_0_0_0_0_0_0_00;
   localparam logic [15:0] DEC_V  = 16'b0_0_000_00_0_0_0_0_0_0_0_00;
   localparam logic [15:0] MOVI_V = 16'b0_0_001_10_1_0_0_0_0_0_0_00;
   localparam logic [15:0] GETA_V = 16'b0_0_001_00_0_1_0_0_0_0_0_00;
   localparam logic [15:0] GETB_V = 16'b0_0_100_00_0_0_1_0_0_0_0_00;
   localparam logic [15:0] WRB_V  = 16'b0_0_010_01_1_0_0_0_0_0_0_00;
   localparam logic [15:0] TRAP_V = 16'b0_1_000_00_0_0_0_0_0_0_0_00;
   localparam logic [15:0] EX_MOV = 16'b0_0_000_00_0_0_0_1_0_1_0_00;
   localparam logic [15:0] EX_ADD = 16'b0_0_000_00_0_0_0_1_0_0_0_00;
   localparam logic [15:0] EX_CMP = 16'b0_0_000_00_0_0_0_0_1_0_0_01;
   localparam logic [15:0] EX_AND = 16'b0_0_000_00_0_0_0_1_0_0_0_10;
   localparam logic [15:0] EX_MVN = 16'b0_0_000_00_0_0_0_1_0_1_0_11;

   logic [15:0] vec;
   assign vec = {w, err, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op};

   alu_seq_ctrl #(.NSEL_W(3), .VSEL_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
      .w(w), .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .alu_op(alu_op), .err(err)
   );

   always #5 clk = ~clk;

   // Model: each instruction is a list of per-cycle output vectors following DECODE.
   logic [15:0] exp_cur = WAIT_V;
   logic [15:0] exp_q[$];

   function automatic void push_seq(input logic [4:0] ins);
      case (ins)
         5'b110_10: exp_q.push_back(MOVI_V);
         5'b110_00: begin
            exp_q.push_back(GETB_V); exp_q.push_back(EX_MOV); exp_q.push_back(WRB_V);
         end
         5'b101_00: begin
            exp_q.push_back(GETA_V); exp_q.push_back(GETB_V);
            exp_q.push_back(EX_ADD); exp_q.push_back(WRB_V);
         end
         5'b101_01: begin
            exp_q.push_back(GETA_V); exp_q.push_back(GETB_V); exp_q.push_back(EX_CMP);
         end
         5'b101_10: begin
            exp_q.push_back(GETA_V); exp_q.push_back(GETB_V);
            exp_q.push_back(EX_AND); exp_q.push_back(WRB_V);
         end
         5'b101_11: begin
            exp_q.push_back(GETB_V); exp_q.push_back(EX_MVN); exp_q.push_back(WRB_V);
         end
         default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            exp_q.push_back(TRAP_V);
`endif
         end
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
         exp_cur <= WAIT_V;
      end else if (exp_q.size() > 0) begin
         exp_cur <= exp_q.pop_front();
      end else if ((exp_cur == WAIT_V) && s) begin
         push_seq({opcode, op});
         exp_cur <= DEC_V;
      end else if (exp_cur != TRAP_V) begin
         exp_cur <= WAIT_V;
      end
   end

   always @(posedge clk) begin
      #1;
      n_chk++;
      if (vec !== exp_cur) begin
         n_fail++;
         $display("FAIL cycle_compare t=%0t: dut %b model %b", $time, vec, exp_cur);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   logic [15:0] got_q[$];

   // Starts one instruction from WAIT and records vectors after each edge until w returns.
   task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input bit chg,
                            output int lat);
      got_q.delete();
      @(negedge clk);
      s = 1'b1; opcode = opc; op = o;
      @(posedge clk); #1;
      s = 1'b0;
      if (chg) begin
         opcode = 3'b110; op = 2'b10;
      end
      got_q.push_back(vec);
      lat = -1;
      for (int k = 2; k <= 20; k++) begin
         @(posedge clk); #1;
         got_q.push_back(vec);
         if (w) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      logic [4:0] legal_tab [6];
      logic [4:0] pick;
      logic any_wr;
      legal_tab = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11};

      repeat (2) @(negedge clk);
      chk("reset_vec", 32'(vec), 32'(WAIT_V));
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_instr(3'b110, 2'b10, 1'b0, lat);
      chk("movi_lat", lat, 3);
      chk("movi_dec", 32'(got_q[0]), 32'(DEC_V));
      chk("movi_wr", 32'(got_q[1]), 32'(MOVI_V));

      run_instr(3'b101, 2'b00, 1'b0, lat);
      chk("add_lat", lat, 6);
      chk("add_geta", 32'(got_q[1]), 32'(GETA_V));
      chk("add_getb", 32'(got_q[2]), 32'(GETB_V));
      chk("add_exec", 32'(got_q[3]), 32'(EX_ADD));
      chk("add_wrb", 32'(got_q[4]), 32'(WRB_V));

      run_instr(3'b101, 2'b01, 1'b0, lat);
      chk("cmp_lat", lat, 5);
      chk("cmp_exec", 32'(got_q[3]), 32'(EX_CMP));
      any_wr = 1'b0;
      foreach (got_q[i]) any_wr |= got_q[i][8];
      chk("cmp_nowrite", 32'(any_wr), 32'd0);

      run_instr(3'b101, 2'b11, 1'b1, lat);
      chk("mvn_lat", lat, 5);
      chk("mvn_getb", 32'(got_q[1]), 32'(GETB_V));
      chk("mvn_exec", 32'(got_q[2]), 32'(EX_MVN));

      run_instr(3'b110, 2'b00, 1'b0, lat);
      chk("movr_lat", lat, 5);
      chk("movr_exec", 32'(got_q[2]), 32'(EX_MOV));

      // s held high: restart on the edge right after returning to WAIT.
      @(negedge clk);
      s = 1'b1; opcode = 3'b110; op = 2'b10;
      repeat (3) @(posedge clk);
      #1 chk("b2b_wait", 32'(w), 32'd1);
      @(posedge clk);
      #1 chk("b2b_restart", 32'(vec), 32'(DEC_V));
      s = 1'b0;
      repeat (4) @(negedge clk);

      // Reset during WRITE of an ADD.
      @(negedge clk);
      s = 1'b1; opcode = 3'b101; op = 2'b00;
      @(posedge clk); #1 s = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("rst_in_write", 32'(vec), 32'(WRB_V));
      #2 reset_n = 1'b0;
      #1 chk("rst_async", 32'(vec), 32'(WAIT_V));
      @(negedge clk);
      reset_n = 1'b1; s = 1'b1; opcode = 3'b101; op = 2'b00;
      @(posedge clk);
      #1 chk("rst_restart", 32'(vec), 32'(DEC_V));
      s = 1'b0;
      repeat (8) @(negedge clk);

      // Randomized traffic, including asynchronous reset pulses.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         s = ($urandom_range(0, 3) != 0);
         pick = legal_tab[$urandom_range(0, 5)];
`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
         if ($urandom_range(0, 7) == 0) pick = 5'($urandom);
`endif
         {opcode, op} = pick;
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            #2 reset_n = 1'b1;
         end
      end
      s = 1'b0;
      repeat (8) @(negedge clk);

      run_instr(3'b111, 2'b00, 1'b0, lat);
      chk("ill_dec", 32'(got_q[0]), 32'(DEC_V));
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      chk("trap_lat", lat, -1);
      chk("trap_vec", 32'(got_q[1]), 32'(TRAP_V));
      repeat (3) begin
         @(negedge clk) s = 1'b1;
         @(negedge clk) s = 1'b0;
      end
      chk("trap_hold", 32'(vec), 32'(TRAP_V));
      reset_n = 1'b0;
      #1 chk("trap_reset", 32'(vec), 32'(WAIT_V));
      @(negedge clk) reset_n = 1'b1;
`else
      chk("ill_lat", lat, 2);
      chk("ill_wait", 32'(got_q[1]), 32'(WAIT_V));
`endif
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
